tx_clkdiv: RTL and testbench



---
 rtl/tx_clkdiv_if.sv | 14 +
 rtl/tx_clkdiv.sv | 46 ++++
 tb/tb_tx_clkdiv.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tx_clkdiv_if.sv
// Divided-clock bundle of the TX serializer clock tree: clkout[k] = clkin / 2^(k+1).
// The divider drives it through the master modport; tree levels read it through slave.
`ifndef SERDES_STAGES
`define SERDES_STAGES 4
`endif

interface tx_clkdiv_if #(
  parameter int STAGES = `SERDES_STAGES - 1
);
  logic [STAGES-1:0] clkout;

  modport master (output clkout);
  modport slave  (input  clkout);
endinterface

// File: rtl/tx_clkdiv.sv
// Binary clock divider for the TX serializer tree, built as a synchronous counter on the clkin falling edge.
// Optional macro TX_CLKDIV_RST_SYNC_EN: synchronizes rstb release through two falling-edge flops.
`ifndef SERDES_STAGES
`define SERDES_STAGES 4
`endif

module tx_clkdiv #(
  parameter int STAGES = `SERDES_STAGES - 1
) (
  input  logic        clkin,
  input  logic        rstb,
  tx_clkdiv_if.master div_if
);

  logic [STAGES-1:0] r_cnt;
  logic              w_cnt_run;

`ifdef TX_CLKDIV_RST_SYNC_EN
  // Assertion stays asynchronous; only the release is retimed to clkin falling edges.
  logic [1:0] r_rst_sync;

  always_ff @(negedge clkin or negedge rstb) begin
    if (!rstb) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_cnt_run = r_rst_sync[1];
`else
  assign w_cnt_run = 1'b1;
`endif

  // Every bit is a flop on the same edge, so all clkout edges are skew-matched.
  always_ff @(negedge clkin or negedge rstb) begin
    if (!rstb) begin
      r_cnt <= '0;
    end else if (w_cnt_run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign div_if.clkout = r_cnt;

endmodule

// File: tb/tb_tx_clkdiv.sv
// Directed bench for tx_clkdiv (STAGES=3): reset hold, release sequence, period/duty, mid-run reset.
// Expected counts come from a small falling-edge model pushed into a scoreboard queue.
`timescale 1ns/1ps

module tb_tx_clkdiv;

  localparam int STAGES = 3;
  localparam time T     = 10ns;
`ifdef TX_CLKDIV_RST_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clkin = 1'b0;
  logic rstb  = 1'b0;

  tx_clkdiv_if #(.STAGES(STAGES)) u_if ();

  tx_clkdiv #(.STAGES(STAGES)) u_dut (
    .clkin  (clkin),
    .rstb   (rstb),
    .div_if (u_if)
  );

  always #(T/2) clkin = ~clkin;

  int checks = 0;
  int errors = 0;

  logic [STAGES-1:0] m_cnt = '0;
  int                m_rel = 0;
  logic [STAGES-1:0] sb_q[$];
  logic [STAGES-1:0] exp_v;
  logic [STAGES-1:0] held;

  time last_rise[STAGES];
  time per[STAGES];
  time hi[STAGES];
  bit  seen_rise[STAGES];
  bit  got_per[STAGES];
  bit  got_hi[STAGES];
  logic [STAGES-1:0] prev_s;
  logic [STAGES-1:0] cur_s;

  task automatic check(input string tag, input logic [STAGES-1:0] obs, input logic [STAGES-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_time(input string tag, input time obs, input time exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0t expected %0t", tag, obs, exp);
    end
  endtask

  // Model one clkin falling edge, push its result, then compare just after the edge.
  task automatic edge_check(input string tag);
    if (!rstb) begin
      m_cnt = '0;
      m_rel = 0;
    end else begin
      m_rel++;
      if (m_rel >= LAT) m_cnt = m_cnt + 1'b1;
    end
    sb_q.push_back(m_cnt);
    @(negedge clkin);
    #1;
    exp_v = sb_q.pop_front();
    check(tag, u_if.clkout, exp_v);
  endtask

  initial begin
    #(100000 * T);
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted from time zero.
    #1;
    check("reset_initial", u_if.clkout, '0);
    for (int i = 0; i < 10; i++) edge_check("reset_hold");

    // Release between edges; first falling edge after release shows 001.
    #2;
    rstb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      edge_check("release_seq");
      held = u_if.clkout;
      @(posedge clkin);
      #1;
      check("no_change_on_rise", u_if.clkout, held);
    end

    // Period and high-time measurement over 40 falling edges.
    for (int k = 0; k < STAGES; k++) begin
      seen_rise[k] = 0; got_per[k] = 0; got_hi[k] = 0;
      last_rise[k] = 0; per[k] = 0; hi[k] = 0;
    end
    prev_s = u_if.clkout;
    for (int i = 0; i < 40; i++) begin
      edge_check("freq_run");
      cur_s = u_if.clkout;
      for (int k = 0; k < STAGES; k++) begin
        if (!prev_s[k] && cur_s[k]) begin
          if (seen_rise[k] && !got_per[k]) begin
            per[k] = $time - last_rise[k];
            got_per[k] = 1;
          end
          last_rise[k] = $time;
          seen_rise[k] = 1;
        end else if (prev_s[k] && !cur_s[k] && seen_rise[k] && !got_hi[k]) begin
          hi[k] = $time - last_rise[k];
          got_hi[k] = 1;
        end
      end
      prev_s = cur_s;
    end
    for (int k = 0; k < STAGES; k++) begin
      check_time($sformatf("period_bit%0d", k), per[k], (2 << k) * T);
      check_time($sformatf("high_bit%0d", k), hi[k], (1 << k) * T);
    end

    // Mid-run reset at count 101, between edges.
    for (int i = 0; i < 16 && m_cnt != 3'b101; i++) edge_check("seek_101");
    check("at_101", u_if.clkout, 3'b101);
    #2;
    rstb = 1'b0;
    m_cnt = '0;
    m_rel = 0;
    #1;
    check("midrun_async_clear", u_if.clkout, 3'b000);
    edge_check("midrun_hold");
    edge_check("midrun_hold");
    #2;
    rstb = 1'b1;
    for (int i = 0; i < LAT + 2; i++) edge_check("rerelease_seq");
    check("rerelease_count3", u_if.clkout, 3'b011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
